// File: rtl/moore_pkg.sv
// Shared definitions for the Moore sequence detector: state encoding constants
// and the combinational KMP fallback used by the next-state logic.
package moore_pkg;

    localparam int SEQ_PAT_W_MAX = 16;
    // Widest state encoding any legal PAT_W needs; narrower instances truncate.
    localparam int SEQ_STATE_W   = $clog2(SEQ_PAT_W_MAX + 2);

    // All-ones is IDLE so that state code k equals match length k.
    localparam logic [SEQ_STATE_W-1:0] SEQ_IDLE = '1;

    // Bit i of the pattern in receive order (i = 0 is the first bit received).
    function automatic logic seq_bit(
        input logic [SEQ_PAT_W_MAX-1:0] pattern,
        input logic [SEQ_STATE_W-1:0]   i,
        input logic [SEQ_STATE_W-1:0]   pat_w
    );
        return pattern[4'(int'(pat_w) - 1 - int'(i))];
    endfunction

    // Longest proper suffix of (first k pattern bits, bit_in) that is also a
    // pattern prefix.
    function automatic logic [SEQ_STATE_W-1:0] seq_fail(
        input logic [SEQ_PAT_W_MAX-1:0] pattern,
        input logic [SEQ_STATE_W-1:0]   k,
        input logic                     bit_in,
        input logic [SEQ_STATE_W-1:0]   pat_w
    );
        int                     kk;
        int                     pw;
        int                     idx;
        logic                   ok;
        logic                   s_bit;
        logic [SEQ_STATE_W-1:0] best;
        kk   = int'(k);
        pw   = int'(pat_w);
        best = '0;
        for (int len = 1; len <= SEQ_PAT_W_MAX; len++) begin
            if (len <= kk) begin
                ok = 1'b1;
                for (int j = 0; j < SEQ_PAT_W_MAX; j++) begin
                    if (j < len) begin
                        idx   = kk + 1 - len + j;
                        s_bit = (idx == kk) ? bit_in : pattern[4'(pw - 1 - idx)];
                        if (s_bit != pattern[4'(pw - 1 - j)]) ok = 1'b0;
                    end
                end
                if (ok) best = SEQ_STATE_W'(len);
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter; a clear request wins over a same-cycle increment.
module seq_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    assign sat = &cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/moore_seq_detect.sv
// Parametrised Moore sequence detector, MSB of PATTERN received first, with
// optional overlapping detection, input enable and saturating match counter.
//
// state  | meaning
// IDLE   | just out of reset; next edge always goes to M0, din ignored
// Mk     | last k received bits equal the first k pattern bits (0 <= k < PAT_W)
// M[W]   | full pattern seen; match = 1
module moore_seq_detect
    import moore_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int                         STATE_W = $clog2(PAT_W + 2);
    localparam logic [STATE_W-1:0]         S_IDLE  = SEQ_IDLE[STATE_W-1:0];
    localparam logic [STATE_W-1:0]         S_M0    = '0;
    localparam logic [STATE_W-1:0]         S_FULL  = STATE_W'(PAT_W);
    localparam logic [SEQ_PAT_W_MAX-1:0]   PAT_EXT = SEQ_PAT_W_MAX'(PATTERN);
    localparam logic [SEQ_STATE_W-1:0]     PW      = SEQ_STATE_W'(PAT_W);

    logic [STATE_W-1:0]     state;
    logic [STATE_W-1:0]     state_next;
    logic [SEQ_STATE_W-1:0] state_ext;
    logic                   next_bit;
    logic                   first_bit;
    logic                   inc;

    always_comb begin
        state_ext  = SEQ_STATE_W'(state);
        next_bit   = seq_bit(PAT_EXT, state_ext, PW);
        first_bit  = seq_bit(PAT_EXT, '0, PW);
        state_next = state;
        if (state == S_IDLE) begin
            state_next = S_M0;
        end else if (en) begin
            if (state == S_FULL && !OVERLAP) begin
                // Non-overlapping: a completed match restarts from M0.
                state_next = (din == first_bit) ? STATE_W'(1) : S_M0;
            end else if (state != S_FULL && din == next_bit) begin
                state_next = state + STATE_W'(1);
            end else begin
                state_next = STATE_W'(seq_fail(PAT_EXT, state_ext, din, PW));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign match = (state == S_FULL);
    assign inc   = en && (state_next == S_FULL);

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc),
        .clr (clr_cnt),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_moore_seq_detect.sv
// Scoreboard bench for moore_seq_detect: three configurations, directed
// vectors with hand-computed expected match / match_cnt / cnt_sat per edge.
module tb_moore_seq_detect;

    logic       clk   = 1'b0;
    logic [2:0] rst_v = 3'b111;
    logic [2:0] en_v  = 3'b000;
    logic [2:0] din_v = 3'b000;
    logic [2:0] clr_v = 3'b000;

    logic       match0, match1, match2;
    logic       sat0, sat1, sat2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    typedef struct {
        int         dut;
        logic       m;
        logic [7:0] c;
        logic       s;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // d0: 1011 overlapping, d1: 1011 non-overlapping, d2: 11 overlapping, 2-bit counter
    moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_d0 (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .din(din_v[0]), .clr_cnt(clr_v[0]),
        .match(match0), .match_cnt(cnt0), .cnt_sat(sat0));

    moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .din(din_v[1]), .clr_cnt(clr_v[1]),
        .match(match1), .match_cnt(cnt1), .cnt_sat(sat1));

    moore_seq_detect #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_d2 (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .din(din_v[2]), .clr_cnt(clr_v[2]),
        .match(match2), .match_cnt(cnt2), .cnt_sat(sat2));

    function automatic void chk(input string name, input string field, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d, required %0d", name, field, act, req);
        end
    endfunction

    // Monitor: one expectation per clock edge, checked on the following falling edge.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic       a_m;
        logic       a_s;
        logic [7:0] a_c;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.dut)
                0:       begin a_m = match0; a_c = cnt0;          a_s = sat0; end
                1:       begin a_m = match1; a_c = cnt1;          a_s = sat1; end
                default: begin a_m = match2; a_c = {6'b0, cnt2};  a_s = sat2; end
            endcase
            chk(e.name, "match",     int'(a_m), int'(e.m));
            chk(e.name, "match_cnt", int'(a_c), int'(e.c));
            chk(e.name, "cnt_sat",   int'(a_s), int'(e.s));
        end
    end

    task automatic step(input int d, input logic r, input logic e, input logic b, input logic c,
                        input logic em, input logic [7:0] ec, input logic es, input string name);
        exp_t x;
        rst_v[2'(d)] = r;
        en_v[2'(d)]  = e;
        din_v[2'(d)] = b;
        clr_v[2'(d)] = c;
        x.dut  = d;
        x.m    = em;
        x.c    = ec;
        x.s    = es;
        x.name = name;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // d0: reset, IDLE swallows the first bit, then the overlapping stream
        repeat (3) step(0, 1, 1, 1, 0, 0, 0, 0, "rst_hold");
        step(0, 0, 1, 1, 0, 0, 0, 0, "idle_ignore");
        step(0, 0, 1, 0, 0, 0, 0, 0, "post_idle_0");
        step(0, 0, 1, 1, 0, 0, 0, 0, "post_idle_1");
        step(0, 0, 1, 1, 0, 0, 0, 0, "first_bit_dropped");
        step(0, 0, 1, 1, 0, 0, 0, 0, "ov_b1");
        step(0, 0, 1, 0, 0, 0, 0, 0, "ov_b2");
        step(0, 0, 1, 1, 0, 0, 0, 0, "ov_b3");
        step(0, 0, 1, 1, 0, 1, 1, 0, "ov_b4_match");
        step(0, 0, 1, 0, 0, 0, 1, 0, "ov_b5");
        step(0, 0, 1, 1, 0, 0, 1, 0, "ov_b6");
        step(0, 0, 1, 1, 0, 1, 2, 0, "ov_b7_match");
        repeat (2) step(0, 0, 0, 1'($urandom_range(0, 1)), 0, 1, 2, 0, "match_hold_en0");
        // d0: enable gating mid-pattern
        step(0, 0, 1, 0, 0, 0, 2, 0, "flush_0a");
        step(0, 0, 1, 0, 0, 0, 2, 0, "flush_0b");
        step(0, 0, 1, 1, 0, 0, 2, 0, "gate_b1");
        step(0, 0, 1, 0, 0, 0, 2, 0, "gate_b2");
        step(0, 0, 1, 1, 0, 0, 2, 0, "gate_b3");
        repeat (5) step(0, 0, 0, 1'($urandom_range(0, 1)), 0, 0, 2, 0, "gate_en0");
        step(0, 0, 1, 1, 0, 1, 3, 0, "gate_match");
        step(0, 0, 0, 0, 1, 1, 0, 0, "clr_only");
        step(0, 0, 0, 0, 0, 1, 0, 0, "clr_after");

        // d1: non-overlapping stream, then reset in the middle of a partial match
        step(1, 0, 1, 0, 0, 0, 0, 0, "nov_idle");
        step(1, 0, 1, 1, 0, 0, 0, 0, "nov_b1");
        step(1, 0, 1, 0, 0, 0, 0, 0, "nov_b2");
        step(1, 0, 1, 1, 0, 0, 0, 0, "nov_b3");
        step(1, 0, 1, 1, 0, 1, 1, 0, "nov_b4_match");
        step(1, 0, 1, 0, 0, 0, 1, 0, "nov_b5");
        step(1, 0, 1, 1, 0, 0, 1, 0, "nov_b6");
        step(1, 0, 1, 1, 0, 0, 1, 0, "nov_b7_nomatch");
        step(1, 0, 1, 0, 0, 0, 1, 0, "nov_flush_a");
        step(1, 0, 1, 0, 0, 0, 1, 0, "nov_flush_b");
        step(1, 0, 1, 1, 0, 0, 1, 0, "mid_b1");
        step(1, 0, 1, 0, 0, 0, 1, 0, "mid_b2");
        step(1, 0, 1, 1, 0, 0, 1, 0, "mid_b3");
        step(1, 1, 1, 1, 0, 0, 0, 0, "mid_rst");
        step(1, 0, 1, 1, 0, 0, 0, 0, "mid_last_ignored");
        step(1, 0, 1, 0, 0, 0, 0, 0, "mid_after_a");
        step(1, 0, 1, 1, 0, 0, 0, 0, "mid_after_b");
        step(1, 0, 1, 1, 0, 0, 0, 0, "mid_after_c");

        // d2: self-overlapping pattern 11, 2-bit counter saturation and clear
        step(2, 0, 1, 0, 0, 0, 0, 0, "sat_idle");
        step(2, 0, 1, 1, 0, 0, 0, 0, "sat_b1");
        step(2, 0, 1, 1, 0, 1, 1, 0, "sat_b2");
        step(2, 0, 1, 1, 0, 1, 2, 0, "sat_b3");
        step(2, 0, 1, 1, 0, 1, 3, 1, "sat_b4");
        step(2, 0, 1, 1, 0, 1, 3, 1, "sat_b5");
        step(2, 0, 1, 1, 0, 1, 3, 1, "sat_b6");
        step(2, 0, 1, 1, 1, 1, 0, 0, "sat_clr_wins");
        step(2, 0, 1, 1, 0, 1, 1, 0, "sat_after_clr");
        step(2, 0, 1, 0, 0, 0, 1, 0, "sat_break");

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/moore_seq_detect.md
# moore_seq_detect

Parametrised Moore sequence detector: the successor to our fixed two-state din-toggle FSM. It matches a configurable PAT_W-bit pattern on a serial bit stream, MSB first, with selectable overlapping or non-overlapping detection, an input enable, and a saturating match counter. It sits directly on serial control/data lines in the datapath. The registered Moore output is fed to downstream FSMs and to status registers.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16
- PATTERN, 4'b1011, PAT_W-bit pattern; bit PAT_W-1 is the first bit received
- OVERLAP, 1, 1 = overlapping detection, 0 = restart after each match
- CNT_W, 8, match counter width; must be >= 1
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  din is sampled only when en=1; when en=0 the state holds
- din  in  1  serial input bit
- clr_cnt  in  1  synchronous clear of match_cnt
- match  out  1  Moore output; 1 exactly while the FSM is in state M[PAT_W]
- match_cnt  out  CNT_W  number of matches seen, saturating
- cnt_sat  out  1  1 when match_cnt is all ones

## Operation
- States: IDLE, M0..M[PAT_W]. Mk means the last k received bits equal the first k pattern bits.
- Encoding: binary, width $clog2(PAT_W+2).
- Reset: state = IDLE, match = 0, match_cnt = 0, cnt_sat = 0.
- IDLE → M0 on the first clock after rst is released, regardless of en and din. din is ignored in IDLE.
- Mk with k < PAT_W, en=1:
  - If din == PATTERN[PAT_W-1-k], go to M[k+1].
  - Otherwise go to M[f]. f is the length of the longest proper suffix of (matched k bits, din) that is also a prefix of PATTERN (KMP failure rule).
  - The failure rule is computed combinationally from the parameters. It is not a stored table.
- M[PAT_W], en=1:
  - OVERLAP=1: apply the failure rule to the full pattern followed by din. This may return directly to M[PAT_W] if the pattern is self-overlapping.
  - OVERLAP=0: take the M0 transition; din == PATTERN[PAT_W-1] → M1, else M0.
- en=0: the state holds in every state except IDLE. match keeps its value.
- Counter:
  - Increments by 1 on any edge where en=1 and the next state is M[PAT_W]. This includes M[PAT_W] → M[PAT_W].
  - Saturates at 2^CNT_W − 1; it never wraps.
  - clr_cnt has priority over a simultaneous increment: the result is 0.
- cnt_sat is combinational from match_cnt.
- rst during a partial match: state returns to IDLE, and the partial match is discarded. match_cnt is also cleared.

## Timing
- din is sampled on the rising edge when en=1.
- The last pattern bit is sampled at edge t. match goes high immediately after edge t and stays high until the next edge where en=1.
- match_cnt updates on the same edge t, so it is visible together with match.
- No combinational path from din to match. match is decoded only from the state register.
- First usable bit: the second edge after rst deasserts. The first edge only performs IDLE → M0.
- clr_cnt takes effect at the next edge; match_cnt reads 0 after that edge.

## Structure
- Package moore_pkg holds:
  - the function seq_fail(pattern, k, bit, pat_w) returning the fallback length;
  - the localparam for the state width;
  - the IDLE state code, which is the all-ones code, keeping M0..M[PAT_W] equal to the numeric k.
- One sub-module, seq_match_cnt: a CNT_W saturating counter with inc/clr inputs (clr wins) and a sat output.
- The top level holds the state register, the next-state logic and the Moore output decode.

## Test plan
- Reset and IDLE:
  - Stimulus: hold rst for 3 cycles, then release with din=1, en=1.
  - Required: state is IDLE for one cycle; match=0; match_cnt=0; the first din is ignored.
- Overlap detection:
  - Stimulus: PATTERN=1011, OVERLAP=1; after IDLE, feed 1,0,1,1,0,1,1.
  - Required: match is high after bit 4 and after bit 7; match_cnt=2.
- Non-overlap detection:
  - Stimulus: same stream with OVERLAP=0.
  - Required: match only after bit 4; match_cnt=1.
- Enable gating:
  - Stimulus: feed 1,0,1, then drop en for 5 cycles with random din, then en=1 and din=1.
  - Required: match fires on that bit; the bits seen while en=0 have no effect.
- Self-overlap and saturation:
  - Stimulus: CNT_W=2, PATTERN=11, OVERLAP=1; feed 6 ones.
  - Required: match is continuous from bit 2 onward; match_cnt saturates at 3 with cnt_sat=1. Then assert clr_cnt together with one more 1.
  - Required after that edge: match_cnt=0 and match=1.
- Mid-pattern reset:
  - Stimulus: PATTERN=1011; feed 1,0,1, assert rst for one cycle, then feed 1.
  - Required: no match; the state goes IDLE → M0, and the final bit is ignored.
